// File: rtl/click_flasher_if.sv
// Click/LED bus between the debounced click source and the flasher.
interface click_flasher_if #(
    parameter int unsigned PEND_W = 8
);
    logic              click;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    // Click source side: drives strobes, observes flasher status.
    modport master (
        output click,
        input  led,
        input  busy,
        input  pending,
        input  overflow
    );

    // Flasher side.
    modport slave (
        input  click,
        output led,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/click_flasher.sv
// Turns single-cycle click strobes into fixed-length LED flashes, queueing
// clicks that arrive mid-flash and replaying them back to back.
module click_flasher #(
    parameter logic [31:0] ON_TIME  = 32'd500_000,
    parameter logic [31:0] OFF_TIME = 32'd500_000,
    parameter int unsigned PEND_W   = 8
) (
    input logic            clk,
    input logic            reset,
    click_flasher_if.slave bus
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StOn   = 2'd1;
    localparam logic [1:0] StOff  = 2'd2;

    localparam logic [PEND_W-1:0] PendMax = '1;

    logic [1:0]        state_q, state_d;
    logic [31:0]       timer_q, timer_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              dequeue;

    // Flash sequencing: timer counts cycles within the ON or OFF phase.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dequeue = 1'b0;
        case (state_q)
            StIdle: begin
                if (pending_q != '0) begin
                    state_d = StOn;
                    timer_d = '0;
                    dequeue = 1'b1;
                end
            end
            StOn: begin
                if (timer_q == ON_TIME - 32'd1) begin
                    state_d = StOff;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            StOff: begin
                if (timer_q == OFF_TIME - 32'd1) begin
                    timer_d = '0;
                    // Queued click starts the next flash with no idle cycle.
                    if (pending_q != '0) begin
                        state_d = StOn;
                        dequeue = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    // Pending queue: a click and a dequeue on the same edge cancel out,
    // so saturation can only drop a click when nothing is leaving.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (bus.click && !dequeue) begin
            if (pending_q == PendMax) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (!bus.click && dequeue) begin
            pending_d = pending_q - PEND_W'(1);
        end
    end

    // Registered outputs follow the next state so they align with it.
    always_comb begin
        led_d  = (state_d == StOn);
        busy_d = (state_d != StIdle);
    end

    // State registers; reset aborts any flash in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.led      = led_q;
    assign bus.busy     = busy_q;
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;
endmodule
